// File: rtl/fp_unit_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_unit_issuer
//  Purpose  : Initiator-side engine for the FP units' stb/ack handshake.
//             Buffers single-precision operands in a small FIFO, issues them
//             one at a time to a single-operand FP unit (input_a port),
//             collects each result (output_z port) and presents it on a
//             valid/ready response port.
//  Ports    : clk, rst            - clock, async active-high reset
//             req_data/valid/ready - operand push port (producer side)
//             unit_a/_stb/_ack     - to/from the unit's input_a handshake
//             unit_z/_stb/_ack     - from/to the unit's output_z handshake
//             rsp_data/valid/ready - result port (consumer side)
//             busy                 - any work queued, in flight or held
//             timeout              - sticky watchdog flag
//  Options  : FP_ISSUER_TIMEOUT_EN - enables the watchdog; otherwise timeout=0
//  Revision : 1.0 - initial release
// ============================================================================
module fp_unit_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_data,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] unit_a,
    output logic        unit_a_stb,
    input  logic        unit_a_ack,
    input  logic [31:0] unit_z,
    input  logic        unit_z_stb,
    output logic        unit_z_ack,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        busy,
    output logic        timeout
);

    localparam int                 c_ADDR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_Z = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [31:0]           r_rsp_data;
    logic                  r_rsp_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;

    // Handshake strobes come only from registered state so the unit never
    // sees a combinational path from its own outputs back to its inputs.
    assign req_ready  = (r_count != c_FULL);
    assign w_push     = req_valid && req_ready;
    assign unit_a_stb = (r_state == ISSUE);
    assign unit_z_ack = (r_state == WAIT_Z) && !r_rsp_valid;
    assign w_pop      = unit_a_stb && unit_a_ack;
    assign w_capture  = unit_z_stb && unit_z_ack;
    assign unit_a     = unit_a_stb ? r_mem[r_rd_ptr] : 32'h0;
    assign rsp_data   = r_rsp_data;
    assign rsp_valid  = r_rsp_valid;
    assign busy       = (r_state != IDLE) || (r_count != '0) || r_rsp_valid;

    // Storage array carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= req_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The operand in flight was popped at issue time, so r_count in WAIT_Z
    // already reflects what is left to send.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_count != '0) w_state_nxt = ISSUE;
            ISSUE:   if (w_pop)         w_state_nxt = WAIT_Z;
            WAIT_Z:  if (w_capture)     w_state_nxt = (r_count != '0) ? ISSUE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture and drain never coincide: unit_z_ack is low while the slot is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data  <= 32'h0;
            r_rsp_valid <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data  <= unit_z;
            r_rsp_valid <= 1'b1;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef FP_ISSUER_TIMEOUT_EN
    localparam int                c_WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic [c_WD_W-1:0] w_wd_inc;
    logic              r_timeout;

    assign w_wd_inc = r_wd_cnt + 1'b1;
    assign timeout  = r_timeout;

    // Counter saturates at the limit; the flag is raised on the same edge
    // the count reaches it and is only cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_state_nxt != r_state) begin
            r_wd_cnt <= '0;
        end else if ((r_state != IDLE) && (r_wd_cnt != c_WD_LIMIT)) begin
            r_wd_cnt <= w_wd_inc;
            if (w_wd_inc == c_WD_LIMIT) r_timeout <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign timeout          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_unit_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_unit_issuer
//  Purpose  : Self-checking bench for fp_unit_issuer. A behavioural FP unit
//             responder with random handshake delays, a random-ready
//             consumer and a queue scoreboard of expected results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_unit_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_data = 32'h0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] unit_a;
    logic        unit_a_stb;
    logic        unit_a_ack = 1'b0;
    logic [31:0] unit_z = 32'h0;
    logic        unit_z_stb = 1'b0;
    logic        unit_z_ack;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        busy;
    logic        timeout;

    always #5 clk = ~clk;

    fp_unit_issuer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
        .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .busy(busy), .timeout(timeout)
    );

    int          checks = 0;
    int          errors = 0;
    int          n_rsp  = 0;
    logic [31:0] exp_q[$];

    // Responder knobs
    int amin = 0, amax = 0, zmin = 0, zmax = 0;
    bit never_z = 1'b0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held off

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Behaviour of the attached "sqrt" unit: exact for the directed operands,
    // an arbitrary fixed mapping for random ones.
    function automatic logic [31:0] unit_fn(input logic [31:0] a);
        case (a)
            32'h40800000: return 32'h40000000;
            32'h41800000: return 32'h40800000;
            32'h42C80000: return 32'h41200000;
            32'h3F800000: return 32'h3F800000;
            default:      return a ^ 32'h5A5AA5A5;
        endcase
    endfunction

    // Unit responder: decides at each falling edge what it presents for the
    // next rising edge; a handshake seen armed at one falling edge completed
    // at the rising edge that followed.
    int          ph = 0, adly = 0, zdly = 0;
    bit          armed = 1'b0, a_pend = 1'b0, z_pend = 1'b0;
    logic [31:0] last_a = 32'h0, held_a = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            ph = 0; armed = 1'b0; a_pend = 1'b0; z_pend = 1'b0;
            unit_a_ack = 1'b0; unit_z_stb = 1'b0; unit_z = 32'h0;
        end else begin
            if (a_pend) begin
                held_a = last_a; unit_a_ack = 1'b0; ph = 1;
                zdly = int'($urandom_range(zmax, zmin));
            end
            if (z_pend) begin
                unit_z_stb = 1'b0; ph = 0;
            end
            if (ph == 0) begin
                if (unit_a_stb && !unit_a_ack) begin
                    if (!armed) begin adly = int'($urandom_range(amax, amin)); armed = 1'b1; end
                    if (adly == 0) begin unit_a_ack = 1'b1; armed = 1'b0; end
                    else adly--;
                end
            end else if (!unit_z_stb && !never_z) begin
                if (zdly == 0) begin unit_z_stb = 1'b1; unit_z = unit_fn(held_a); end
                else zdly--;
            end
            a_pend = unit_a_stb && unit_a_ack;
            if (a_pend) last_a = unit_a;
            z_pend = unit_z_stb && unit_z_ack;
        end
    end

    // Consumer and scoreboard
    always @(negedge clk) begin
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(3, 0) != 0);
            default: rsp_ready = 1'b0;
        endcase
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("rsp_data", rsp_data, exp_q.pop_front());
                n_rsp++;
            end
            if (unit_z_stb && rsp_valid) chk("z_ack_low_while_full", {31'b0, unit_z_ack}, 32'd0);
        end
    end

    // Call at a falling edge; returns at the falling edge after the push.
    task automatic push(input logic [31:0] d);
        int n = 0;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        chk("push_accepted", {31'b0, req_ready}, 32'd1);
        if (req_ready) exp_q.push_back(unit_fn(d));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin @(negedge clk); n++; end
        chk(tag, {31'b0, (exp_q.size() == 0) && !busy}, 32'd1);
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_stb",       {31'b0, unit_a_stb}, 32'd0);
        chk("rst_zack",      {31'b0, unit_z_ack}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready},  32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid},  32'd0);
        chk("rst_rsp_data",  rsp_data,            32'd0);
        chk("rst_unit_a",    unit_a,              32'd0);
        chk("rst_busy",      {31'b0, busy},       32'd0);
        chk("rst_timeout",   {31'b0, timeout},    32'd0);

        // Single operand: sqrt(4.0) with issue timing
        rdy_mode = 0;
        push(32'h40800000);
        chk("stb_not_before_issue", {31'b0, unit_a_stb}, 32'd0);
        chk("busy_after_push",      {31'b0, busy},       32'd1);
        @(negedge clk);
        chk("stb_in_issue", {31'b0, unit_a_stb}, 32'd1);
        chk("unit_a_head",  unit_a,              32'h40800000);
        wait_drain(200, "drain_single");
        chk("single_rsp_count", 32'(n_rsp), 32'd1);
        chk("busy_returns_0",   {31'b0, busy}, 32'd0);

        // Back-to-back fill with a slow unit: queue full after the 4th push
        amin = 10; amax = 10;
        base = n_rsp;
        push(32'h41800000);
        push(32'h42C80000);
        push(32'h3F800000);
        push(32'h40800000);
        chk("full_req_ready", {31'b0, req_ready}, 32'd0);
        wait_drain(500, "drain_fill");
        chk("fill_rsp_count", 32'(n_rsp - base), 32'd4);

        // Response slot held off for 50 cycles with two operands
        amin = 0; amax = 0; zmin = 2; zmax = 2;
        rdy_mode = 2;
        base = n_rsp;
        push(32'h3F800000);
        push(32'h41800000);
        repeat (50) @(negedge clk);
        chk("hold_rsp_valid", {31'b0, rsp_valid},  32'd1);
        chk("hold_rsp_data",  rsp_data,            32'h3F800000);
        chk("hold_unit_stb",  {31'b0, unit_z_stb}, 32'd1);
        chk("hold_zack_low",  {31'b0, unit_z_ack}, 32'd0);
        rdy_mode = 0;
        wait_drain(200, "drain_hold");
        chk("hold_rsp_count", 32'(n_rsp - base), 32'd2);

        // Random operands, random handshake delays, random consumer
        amin = 0; amax = 7; zmin = 0; zmax = 20;
        rdy_mode = 1;
        base = n_rsp;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            push($urandom);
        end
        wait_drain(20000, "drain_random");
        chk("random_rsp_count", 32'(n_rsp - base), 32'd200);

        // Watchdog: the unit never produces a result
        amin = 0; amax = 0; zmin = 0; zmax = 0;
        rdy_mode = 0; never_z = 1'b1;
        push(32'h40800000);
        n = 0;
        while (!unit_z_ack && n < 100) begin @(negedge clk); n++; end
        chk("enter_wait_z", {31'b0, unit_z_ack}, 32'd1);
        repeat (16) @(negedge clk);
`ifdef FP_ISSUER_TIMEOUT_EN
        chk("timeout_set",  {31'b0, timeout}, 32'd1);
        repeat (20) @(negedge clk);
        chk("timeout_held", {31'b0, timeout}, 32'd1);
`else
        chk("timeout_off",      {31'b0, timeout}, 32'd0);
        repeat (20) @(negedge clk);
        chk("timeout_off_late", {31'b0, timeout}, 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; never_z = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("timeout_cleared", {31'b0, timeout}, 32'd0);

        // Asynchronous reset mid-WAIT_Z with two operands queued
        rdy_mode = 2; zmin = 1; zmax = 1;
        push(32'h40800000);
        push(32'h41800000);
        push(32'h42C80000);
        push(32'h3F800000);
        n = 0;
        while (!(unit_z_stb && rsp_valid) && n < 200) begin @(negedge clk); n++; end
        chk("pre_rst_rsp_data", rsp_data, 32'h40000000);
        chk("pre_rst_full_wait", {31'b0, unit_z_stb && rsp_valid && !unit_z_ack}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_unit_a",    unit_a,              32'd0);
        chk("arst_stb",       {31'b0, unit_a_stb}, 32'd0);
        chk("arst_zack",      {31'b0, unit_z_ack}, 32'd0);
        chk("arst_rsp_valid", {31'b0, rsp_valid},  32'd0);
        chk("arst_rsp_data",  rsp_data,            32'd0);
        chk("arst_busy",      {31'b0, busy},       32'd0);
        chk("arst_timeout",   {31'b0, timeout},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_busy",      {31'b0, busy},      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_unit_issuer.md
# fp_unit_issuer

Initiator-side engine for the floating-point units' stb/ack handshake: buffers single-precision operands from a producer and drives them, one transaction at a time, into a single-operand unit (e.g. `sqrt`) on its `input_a`/`input_a_stb`/`input_a_ack` port. It collects each result from the unit's `output_z`/`output_z_stb`/`output_z_ack` port and presents it on a valid/ready response port. It sits between the datapath sequencer and any single-operand FP unit.

## Interface
- `DEPTH`, 4: operand queue entries; power of two, ≥2.
- `TIMEOUT`, 1023: watchdog limit in cycles; only used with `FP_ISSUER_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_data` in 32: IEEE-754 single operand.
- `req_valid` in 1: operand offered.
- `req_ready` out 1: queue not full.
- `unit_a` out 32: connects to the unit's `input_a`.
- `unit_a_stb` out 1: connects to `input_a_stb`.
- `unit_a_ack` in 1: from `input_a_ack`.
- `unit_z` in 32: from `output_z`.
- `unit_z_stb` in 1: from `output_z_stb`.
- `unit_z_ack` out 1: connects to `output_z_ack`.
- `rsp_data` out 32: result.
- `rsp_valid` out 1: result held.
- `rsp_ready` in 1: consumer takes result.
- `busy` out 1: `state!=IDLE || count!=0 || rsp_valid`.
- `timeout` out 1: sticky watchdog flag.

## Operation
- Queue: `DEPTH`-entry FIFO with wrap-around read/write pointers and a `$clog2(DEPTH)+1`-bit count.
  - Push when `req_valid && req_ready`; `req_ready = (count != DEPTH)`.
  - Pop on an issue transfer.
  - Simultaneous push and pop leaves count unchanged.
  - No bypass: an operand pushed into an empty queue is first visible at the head on the next cycle.
- FSM states:
  - IDLE: go to ISSUE when `count != 0`.
  - ISSUE: `unit_a_stb = 1`, `unit_a = head`. On an edge with `unit_a_stb && unit_a_ack`, pop and go to WAIT_Z.
  - WAIT_Z: `unit_z_ack = !rsp_valid`. On an edge with `unit_z_stb && unit_z_ack`, load `rsp_data <= unit_z`, set `rsp_valid`, then go to ISSUE if the post-pop count is non-zero, else IDLE.
- `unit_a_stb` and `unit_z_ack` are decoded from the registered state and `rsp_valid` only. Neither depends combinationally on unit inputs.
- Exactly one transaction is in flight at a time. Issue of the next operand overlaps with the response being held.
- Response slot:
  - `rsp_valid` clears on an edge with `rsp_valid && rsp_ready`.
  - While the slot is full, WAIT_Z holds `unit_z_ack` low, so the unit keeps its stb high and no result is lost.
  - Capture and drain on the same edge is impossible, because ack is low whenever the slot is full.
- Results are returned in queue order. Data is passed through unmodified; NaN/inf/denormal handling belongs to the unit.
- Reset: async assertion immediately forces IDLE, empties the queue, and clears `rsp_valid`, `rsp_data`, `unit_a`, `unit_a_stb`, `unit_z_ack` and `timeout` to 0. Any in-flight transaction is abandoned; the attached unit shares `rst`.

## Timing
- Push at edge N into an empty, idle block: ISSUE entered at N+1, and `unit_a_stb` is high in the cycle following N+1.
- Issue transfer at edge M: state is WAIT_Z from M, and `unit_z_ack` is high in the following cycle (if the slot is empty).
- Result capture at edge K: `rsp_valid` is high from K.
  - `unit_z_ack` is low from K.
  - If more operands are queued, `unit_a_stb` is high from K.
- Sustained throughput is bounded by unit latency plus 2 cycles per operand.

## Configuration
- `FP_ISSUER_TIMEOUT_EN` defined:
  - A watchdog counter resets on every state change and increments each cycle in ISSUE or WAIT_Z.
  - When the count reaches `TIMEOUT`, `timeout` sets and stays set until reset.
  - The transaction is not aborted.
- Not defined: the counter is absent and `timeout` is tied to 0.

## Test plan
- Reset, then push 0x40800000 (4.0) into an issuer wired to the `sqrt` unit, with `rsp_ready`=1: `rsp_data`=0x40000000 once; `busy` returns to 0.
- Push 0x41800000, 0x42C80000, 0x3F800000, 0x40800000 back-to-back with `DEPTH`=4: `req_ready` drops after the 4th push. Responses 0x40800000, 0x41200000, 0x3F800000, 0x40000000 arrive in order.
- Hold `rsp_ready`=0 for 50 cycles with two operands queued: the first result is held and `unit_z_ack` stays 0 while the unit's stb is high. The second result follows after release with no loss or duplication.
- Use a bench responder that delays `input_a_ack` by 0–7 random cycles and `output_z_stb` by 0–20 over 200 random operands: the response stream matches a scoreboard exactly.
- With `FP_ISSUER_TIMEOUT_EN` and `TIMEOUT`=16, have the responder never raise `output_z_stb`: `timeout`=1 by 16 cycles into WAIT_Z and stays 1. Without the macro, `timeout` stays 0.
- Assert `rst` mid-WAIT_Z with 2 operands queued: all outputs are 0 immediately and `req_ready`=1 after release.
